// File: rtl/digit_entry_pkg.sv
// rtl/digit_entry_pkg.sv - shared state encoding and width helper for digit entry
package digit_entry_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_ENTERING = 2'd1,
        ST_FULL     = 2'd2
    } entry_state_e;

    function automatic int cnt_w(input int num_digits);
        return $clog2(num_digits + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchroniser plus stable-level debouncer with press pulse
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          meta_q, sync_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter only runs while the synchronised input disagrees with the accepted level.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync_q;
                press_d = sync_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q  <= btn_raw;
            sync_q  <= meta_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/digit_entry.sv
// rtl/digit_entry.sv - switch digit capture into a code register with valid/ack handshake
module digit_entry
    import digit_entry_pkg::*;
#(
    parameter int DIGIT_W         = 4,
    parameter int NUM_DIGITS      = 4,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DIGIT_W-1:0]                sw,
    input  logic                              enter_btn,
    input  logic                              clear_btn,
    input  logic                              code_ack,
    output logic [DIGIT_W-1:0]                digit,
    output logic [NUM_DIGITS*DIGIT_W-1:0]     code,
    output logic [cnt_w(NUM_DIGITS)-1:0]      count,
    output logic                              entry_stb,
    output logic                              code_valid
);

    localparam int CNT_W  = cnt_w(NUM_DIGITS);
    localparam int CODE_W = NUM_DIGITS * DIGIT_W;

    logic [DIGIT_W-1:0] sw_meta_q, sw_sync_q;
    logic [CODE_W-1:0]  code_q, code_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               stb_q, stb_d;
    entry_state_e       state_q, state_d;

    logic enter_press, clear_press, enter_level, clear_level;
    logic unused_levels;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (enter_btn),
        .level   (enter_level),
        .press   (enter_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (clear_btn),
        .level   (clear_level),
        .press   (clear_press)
    );

    assign unused_levels = enter_level ^ clear_level;

    // Priority: clear, then ack while full, then enter (ignored once full).
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        count_d = count_q;
        stb_d   = 1'b0;
        if (clear_press) begin
            state_d = ST_EMPTY;
            code_d  = '0;
            count_d = '0;
        end else if (state_q == ST_FULL) begin
            if (code_ack) begin
                state_d = ST_EMPTY;
                code_d  = '0;
                count_d = '0;
            end
        end else if (enter_press) begin
            code_d  = (code_q << DIGIT_W) | CODE_W'(sw_sync_q);
            count_d = count_q + CNT_W'(1);
            stb_d   = 1'b1;
            state_d = (count_q == CNT_W'(NUM_DIGITS - 1)) ? ST_FULL : ST_ENTERING;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            code_q    <= '0;
            count_q   <= '0;
            stb_q     <= 1'b0;
            state_q   <= ST_EMPTY;
        end else begin
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
            code_q    <= code_d;
            count_q   <= count_d;
            stb_q     <= stb_d;
            state_q   <= state_d;
        end
    end

    assign digit      = sw_sync_q;
    assign code       = code_q;
    assign count      = count_q;
    assign entry_stb  = stb_q;
    assign code_valid = (state_q == ST_FULL);

endmodule

// File: tb/tb_digit_entry.sv
// tb/tb_digit_entry.sv - directed self-checking bench for digit_entry
module tb_digit_entry;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  sw = 4'h0;
    logic        enter_btn = 1'b0;
    logic        clear_btn = 1'b0;
    logic        code_ack = 1'b0;
    logic [3:0]  digit;
    logic [15:0] code;
    logic [2:0]  count;
    logic        entry_stb;
    logic        code_valid;

    int n_checks = 0;
    int n_fail   = 0;
    int stb_cnt  = 0;
    int stb_base;

    digit_entry #(.DIGIT_W(4), .NUM_DIGITS(4), .DEBOUNCE_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .sw         (sw),
        .enter_btn  (enter_btn),
        .clear_btn  (clear_btn),
        .code_ack   (code_ack),
        .digit      (digit),
        .code       (code),
        .count      (count),
        .entry_stb  (entry_stb),
        .code_valid (code_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (entry_stb) stb_cnt <= stb_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_enter(input logic [3:0] d);
        sw = d;
        enter_btn = 1'b1;
        cycles(10);
        enter_btn = 1'b0;
        cycles(10);
    endtask

    initial begin
        cycles(2);
        check("rst_digit", digit, 4'h0);
        check("rst_code", code, 16'h0);
        check("rst_count", count, 3'd0);
        check("rst_valid", code_valid, 1'b0);
        check("rst_stb", entry_stb, 1'b0);
        rst = 1'b0;
        cycles(2);

        sw = 4'hA;
        cycles(1);
        check("digit_1cyc", digit, 4'h0);
        cycles(1);
        check("digit_2cyc", digit, 4'hA);

        stb_base = stb_cnt;
        press_enter(4'h3);
        check("e1_count", count, 3'd1);
        check("e1_valid", code_valid, 1'b0);
        press_enter(4'h7);
        check("e2_count", count, 3'd2);
        press_enter(4'h1);
        check("e3_count", count, 3'd3);
        check("e3_code", code, 16'h0371);
        press_enter(4'h9);
        check("e4_count", count, 3'd4);
        check("e4_code", code, 16'h3719);
        check("e4_valid", code_valid, 1'b1);
        check("e4_stbs", stb_cnt - stb_base, 4);

        stb_base = stb_cnt;
        press_enter(4'h5);
        check("full_code", code, 16'h3719);
        check("full_count", count, 3'd4);
        check("full_stb", stb_cnt - stb_base, 0);
        check("full_valid", code_valid, 1'b1);
        code_ack = 1'b1;
        cycles(1);
        code_ack = 1'b0;
        check("ack_code", code, 16'h0);
        check("ack_count", count, 3'd0);
        check("ack_valid", code_valid, 1'b0);

        stb_base = stb_cnt;
        sw = 4'h6;
        for (int i = 0; i < 3; i++) begin
            enter_btn = 1'b1;
            cycles(2);
            enter_btn = 1'b0;
            cycles(2);
        end
        enter_btn = 1'b1;
        cycles(10);
        enter_btn = 1'b0;
        cycles(10);
        check("bounce_stb", stb_cnt - stb_base, 1);
        check("bounce_code", code, 16'h0006);

        stb_base = stb_cnt;
        enter_btn = 1'b1;
        cycles(3);
        enter_btn = 1'b0;
        cycles(10);
        check("short_stb", stb_cnt - stb_base, 0);
        check("short_count", count, 3'd1);

        clear_btn = 1'b1;
        cycles(10);
        clear_btn = 1'b0;
        cycles(10);
        check("clr_count", count, 3'd0);
        press_enter(4'h2);
        press_enter(4'h4);
        check("pre_both_code", code, 16'h0024);
        stb_base = stb_cnt;
        enter_btn = 1'b1;
        clear_btn = 1'b1;
        cycles(10);
        enter_btn = 1'b0;
        clear_btn = 1'b0;
        cycles(10);
        check("both_count", count, 3'd0);
        check("both_code", code, 16'h0);
        check("both_stb", stb_cnt - stb_base, 0);

        press_enter(4'h1);
        press_enter(4'h2);
        press_enter(4'h3);
        check("pre_rst_code", code, 16'h0123);
        sw = 4'hF;
        enter_btn = 1'b1;
        cycles(3);
        #2 rst = 1'b1;
        #1;
        check("arst_code", code, 16'h0);
        check("arst_count", count, 3'd0);
        check("arst_digit", digit, 4'h0);
        check("arst_valid", code_valid, 1'b0);
        check("arst_stb", entry_stb, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        enter_btn = 1'b0;
        cycles(10);
        press_enter(4'h5);
        check("post_code", code, 16'h0005);
        check("post_count", count, 3'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
